hamming_stream_packager: RTL and testbench
==========================================

HAMMING_STREAM_PACKAGER -- requirements
Module: hamming_stream_packager

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bits per lane, minimum 1.
REQ-002 Parameter LANES, default 1: parallel lanes sharing one handshake, minimum 1.
REQ-003 Parameter COUNT_WIDTH, default 16: width of block counter.
REQ-004 Derived: PARITY_WIDTH = smallest P with 2^P >= DATA_WIDTH+P+1; BLOCK_WIDTH = DATA_WIDTH+PARITY_WIDTH.
REQ-005 clock  input  1  single clock, all state on rising edge.
REQ-006 resetn  input  1  reset; synchronous, active-low.
REQ-007 data  input  LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 data_valid  input  1  upstream data present.
REQ-009 data_ready  output  1  block accepts data this cycle.
REQ-010 block  output  LANES*BLOCK_WIDTH  lane k at bits [k*BLOCK_WIDTH +: BLOCK_WIDTH].
REQ-011 block_valid  output  1  block holds valid output.
REQ-012 block_ready  input  1  downstream accepts block.
REQ-013 block_count  output  COUNT_WIDTH  output handshakes completed since reset, saturating.
REQ-014 count_clear  input  1  synchronous clear of block_count.

Function
REQ-015 Two-stage pipeline: stage 1 registers raw data; stage 2 registers encoded, packed blocks.
REQ-016 Transfer in on data_valid&&data_ready; transfer out on block_valid&&block_ready.
REQ-017 Latency: accepted word appears on block two cycles after acceptance when unstalled; throughput one word/cycle.
REQ-018 Stage 2 loads when stage 2 empty or draining this cycle; stage 1 loads when stage 1 empty or advancing this cycle.
REQ-019 data_ready = !s1_valid || s1_advance; combinational path from block_ready to data_ready permitted.
REQ-020 While block_valid&&!block_ready, block SHALL hold stable; no data dropped or duplicated.
REQ-021 Encoding per lane: 1-indexed block position 2^i holds parity bit i; remaining positions hold data bits in ascending order.
REQ-022 Parity bit i = XOR of all data bits whose 1-indexed block position has bit i set (even parity).
REQ-023 Unused padded positions above BLOCK_WIDTH are truncated, never output.
REQ-024 Lanes are encoded independently; lane k output depends only on lane k input.
REQ-025 block_count increments on each output handshake, saturates at all-ones; count_clear has priority over increment.
REQ-026 Simultaneous load and drain on either stage SHALL preserve order and full throughput.

Reset
REQ-027 On resetn low at clock edge: stage valids, block_valid, block_count to 0; block to 0.
REQ-028 data_ready SHALL read 1 in the first cycle after reset deasserts.
REQ-029 Reset mid-operation discards in-flight words; no output handshake occurs in the reset cycle.

Configuration
REQ-030 Macro HAMMING_STREAM_PACKAGER_ERROR_INJECTION_EN defined: adds input inject_mask (LANES*BLOCK_WIDTH), XORed into each lane's block when stage 2 loads.
REQ-031 Macro undefined: no inject_mask port; output is pure encoding.
REQ-032 inject_mask is sampled only on the stage 2 load cycle; held blocks are unaffected by later mask changes.

Structure
REQ-033 Package hamming_pkg holds functions get_parity_width(data_width), get_data_width(parity_width), and block-position helper constants.
REQ-034 Sub-module hamming_lane_encoder: combinational single-lane encode-and-pack, instantiated LANES times in stage 2 input logic.

Verification
REQ-035 DATA_WIDTH=8, LANES=1: data 8'h00 -> block 12'h000; 8'h01 -> 12'h007; 8'hFF -> 12'hF77, each two cycles after acceptance.
REQ-036 Back-to-back 16 words with block_ready=1 -> 16 blocks on consecutive cycles, in order, block_count=16.
REQ-037 block_ready=0 for 5 cycles with valid stream -> data_ready low after two accepted words, block stable, no loss on release.
REQ-038 LANES=2, data {8'hFF,8'h01} -> block {12'hF77,12'h007}.
REQ-039 COUNT_WIDTH=4, 20 handshakes -> block_count holds 4'hF; count_clear with handshake same cycle -> 0.
REQ-040 With injection macro, inject_mask 12'h004 on data 8'h01 -> block 12'h003; resetn low mid-stream -> block_valid 0 next cycle, count 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming helpers: parity sizing and block-position arithmetic.
// Used by hamming_lane_encoder and hamming_stream_packager.
package hamming_pkg;

   // Block positions are 1-indexed; position 2^i carries parity bit i.
   localparam int unsigned POS_FIRST  = 1;
   localparam int unsigned MAX_PARITY = 24;

   // Smallest P with 2^P >= data_width + P + 1.
   function automatic int unsigned get_parity_width(
      input int unsigned data_width
   );
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < MAX_PARITY; i++) begin
         if ((32'd1 << p) < data_width + p + 1) begin
            p = p + 1;
         end
      end
      return p;
   endfunction

   // Largest data width a given parity width protects.
   function automatic int unsigned get_data_width(
      input int unsigned parity_width
   );
      return (32'd1 << parity_width) - parity_width - 1;
   endfunction

   function automatic bit is_parity_pos(input int unsigned pos);
      return (pos != 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // Data bit index held at a non-parity position: every position
   // below it that is a power of two is a parity slot, and there are
   // clog2(pos) of those when pos is not itself a power of two.
   function automatic int unsigned data_index(input int unsigned pos);
      return pos - POS_FIRST - $clog2(pos);
   endfunction

endpackage

// File: rtl/hamming_lane_encoder.sv
// Single-lane combinational Hamming encode and pack (even parity).
// Ports: data [DATA_WIDTH] in, block [DATA_WIDTH+parity] out.
module hamming_lane_encoder
   import hamming_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH   = 8,
   localparam int unsigned PARITY_WIDTH = get_parity_width(DATA_WIDTH),
   localparam int unsigned BLOCK_WIDTH  = DATA_WIDTH + PARITY_WIDTH
) (
   input  logic [DATA_WIDTH-1:0]  data,
   output logic [BLOCK_WIDTH-1:0] block
);

   // Data bits whose block position has bit `bit_i` set.
   function automatic logic [DATA_WIDTH-1:0] cover_mask(
      input int unsigned bit_i
   );
      logic [DATA_WIDTH-1:0] m;
      m = '0;
      for (int unsigned pos = POS_FIRST; pos <= BLOCK_WIDTH; pos++) begin
         if (!is_parity_pos(pos) && ((pos >> bit_i) & 32'd1) != 0) begin
            m = m | (DATA_WIDTH'(1) << data_index(pos));
         end
      end
      return m;
   endfunction

   // Positions beyond BLOCK_WIDTH are never generated, so the
   // padded tail of the ideal code is simply absent.
   for (genvar g = 1; g <= BLOCK_WIDTH; g++) begin : g_pos
      if (is_parity_pos(g)) begin : g_par
         localparam int unsigned BIT_I = $clog2(g);
         localparam logic [DATA_WIDTH-1:0] COVER = cover_mask(BIT_I);
         assign block[g-1] = ^(data & COVER);
      end else begin : g_dat
         localparam int unsigned D_IDX = data_index(g);
         assign block[g-1] = data[D_IDX];
      end
   end

endmodule

// File: rtl/hamming_stream_packager.sv
// Two-stage valid/ready pipeline: stage 1 holds raw words, stage 2
// holds Hamming-encoded blocks for LANES independent lanes.
// Ports: clock, resetn (sync, active-low); data/data_valid/data_ready
// in; block/block_valid/block_ready out; block_count (saturating
// output handshakes) with count_clear.
// HAMMING_STREAM_PACKAGER_ERROR_INJECTION_EN adds inject_mask, XORed
// into the block as stage 2 loads.
module hamming_stream_packager
   import hamming_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH   = 8,
   parameter  int unsigned LANES        = 1,
   parameter  int unsigned COUNT_WIDTH  = 16,
   localparam int unsigned PARITY_WIDTH = get_parity_width(DATA_WIDTH),
   localparam int unsigned BLOCK_WIDTH  = DATA_WIDTH + PARITY_WIDTH
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic [LANES*DATA_WIDTH-1:0]  data,
   input  logic                         data_valid,
   output logic                         data_ready,
   output logic [LANES*BLOCK_WIDTH-1:0] block,
   output logic                         block_valid,
   input  logic                         block_ready,
   output logic [COUNT_WIDTH-1:0]       block_count,
   input  logic                         count_clear
`ifdef HAMMING_STREAM_PACKAGER_ERROR_INJECTION_EN
   ,
   input  logic [LANES*BLOCK_WIDTH-1:0] inject_mask
`endif
);

   logic                         s1_valid;
   logic [LANES*DATA_WIDTH-1:0]  s1_data;
   logic                         s1_advance;
   logic                         s2_load;
   logic                         block_fire;
   logic [LANES*BLOCK_WIDTH-1:0] enc_block;
   logic [LANES*BLOCK_WIDTH-1:0] s2_next;

   assign block_fire = block_valid && block_ready;

   // Stage 2 takes a word whenever it is empty or emptying now.
   assign s2_load    = s1_valid && (!block_valid || block_ready);
   assign s1_advance = s2_load;

   // Ready may depend on block_ready combinationally; this keeps a
   // full pipeline moving at one word per cycle.
   assign data_ready = !s1_valid || s1_advance;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         if (data_ready) begin
            s1_valid <= data_valid;
         end
         if (data_valid && data_ready) begin
            s1_data <= data;
         end
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      hamming_lane_encoder #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_enc (
         .data  (s1_data[k*DATA_WIDTH +: DATA_WIDTH]),
         .block (enc_block[k*BLOCK_WIDTH +: BLOCK_WIDTH])
      );
   end

`ifdef HAMMING_STREAM_PACKAGER_ERROR_INJECTION_EN
   // Mask is captured with the block; a held block ignores it.
   assign s2_next = enc_block ^ inject_mask;
`else
   assign s2_next = enc_block;
`endif

   always_ff @(posedge clock) begin
      if (!resetn) begin
         block_valid <= 1'b0;
         block       <= '0;
      end else if (s2_load) begin
         block_valid <= 1'b1;
         block       <= s2_next;
      end else if (block_fire) begin
         block_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         block_count <= '0;
      end else if (count_clear) begin
         block_count <= '0;
      end else if (block_fire && (block_count != '1)) begin
         block_count <= block_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hamming_stream_packager.sv
// Scoreboard bench: A is 8-bit x 2 lanes, 16-bit count; B is 8-bit x 1
// lane, 4-bit count, driven with lane 0 of the same stream.
module tb_hamming_stream_packager;

   logic        clock;
   logic        resetn;
   logic [15:0] data;
   logic        data_valid;
   logic        block_ready;
   logic        count_clear;
`ifdef HAMMING_STREAM_PACKAGER_ERROR_INJECTION_EN
   logic [23:0] inject_mask;
`endif

   logic        a_data_ready;
   logic [23:0] a_block;
   logic        a_block_valid;
   logic [15:0] a_count;

   logic        b_data_ready;
   logic [11:0] b_block;
   logic        b_block_valid;
   logic [3:0]  b_count;

   int total = 0;
   int bad   = 0;

   logic [23:0] sbq[$];
   bit          sb_en  = 1'b1;
   bit          held_v = 1'b0;
   logic [23:0] held;

   hamming_stream_packager #(
      .DATA_WIDTH  (8),
      .LANES       (2),
      .COUNT_WIDTH (16)
   ) u_a (
      .clock       (clock),
      .resetn      (resetn),
      .data        (data),
      .data_valid  (data_valid),
      .data_ready  (a_data_ready),
      .block       (a_block),
      .block_valid (a_block_valid),
      .block_ready (block_ready),
      .block_count (a_count),
      .count_clear (count_clear)
`ifdef HAMMING_STREAM_PACKAGER_ERROR_INJECTION_EN
      ,
      .inject_mask (inject_mask)
`endif
   );

   hamming_stream_packager #(
      .DATA_WIDTH  (8),
      .LANES       (1),
      .COUNT_WIDTH (4)
   ) u_b (
      .clock       (clock),
      .resetn      (resetn),
      .data        (data[7:0]),
      .data_valid  (data_valid),
      .data_ready  (b_data_ready),
      .block       (b_block),
      .block_valid (b_block_valid),
      .block_ready (block_ready),
      .block_count (b_count),
      .count_clear (count_clear)
`ifdef HAMMING_STREAM_PACKAGER_ERROR_INJECTION_EN
      ,
      .inject_mask (inject_mask[11:0])
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: XOR of the positions of all set data bits is the
   // parity vector (syndrome formulation).
   function automatic logic [11:0] enc_ref(input logic [7:0] d);
      int          dpos[8];
      logic [11:0] b;
      logic [3:0]  syn;
      dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
      b    = '0;
      syn  = '0;
      for (int k = 0; k < 8; k++) begin
         if (((d >> k) & 8'd1) != 8'd0) begin
            b   = b | (12'd1 << (dpos[k] - 1));
            syn = syn ^ 4'(dpos[k]);
         end
      end
      b[0] = syn[0];
      b[1] = syn[1];
      b[3] = syn[2];
      b[7] = syn[3];
      return b;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      if (resetn) begin
         if (sb_en && a_block_valid && block_ready) begin
            if (sbq.size() == 0) begin
               check("sb_underflow", 64'(1), 64'(0));
            end else begin
               check("sb_block", 64'(a_block), 64'(sbq.pop_front()));
            end
            check("b_lane0", 64'({b_block_valid, b_block}),
                  64'({1'b1, a_block[11:0]}));
         end
         if (held_v && a_block_valid) begin
            check("hold_stable", 64'(a_block), 64'(held));
         end
         held_v = a_block_valid && !block_ready;
         held   = a_block;
         if (sb_en && data_valid && a_data_ready) begin
            sbq.push_back({enc_ref(data[15:8]), enc_ref(data[7:0])});
         end
      end else begin
         held_v = 1'b0;
      end
   end

   // One word, fixed two-cycle latency, known constant result.
   task automatic send_check(input logic [15:0] d, input logic [23:0] e);
      step();
      data       = d;
      data_valid = 1'b1;
      @(negedge clock);
      check("acc_ready", 64'(a_data_ready), 64'(1));
      step();
      data_valid = 1'b0;
      @(negedge clock);
      check("lat_early", 64'(a_block_valid), 64'(0));
      step();
      @(negedge clock);
      check("lat_valid", 64'(a_block_valid), 64'(1));
      check("lat_block", 64'(a_block), 64'(e));
   endtask

   initial begin
      int nacc;
      bit acc;
      resetn      = 1'b0;
      data        = '0;
      data_valid  = 1'b0;
      block_ready = 1'b1;
      count_clear = 1'b0;
`ifdef HAMMING_STREAM_PACKAGER_ERROR_INJECTION_EN
      inject_mask = '0;
`endif
      step();
      step();
      @(negedge clock);
      check("rst_valid", 64'(a_block_valid), 64'(0));
      check("rst_block", 64'(a_block), 64'(0));
      check("rst_count", 64'(a_count), 64'(0));
      check("rst_count_b", 64'(b_count), 64'(0));
      step();
      resetn = 1'b1;
      @(negedge clock);
      check("rst_ready", 64'(a_data_ready), 64'(1));

      send_check(16'h0000, 24'h000000);
      send_check(16'hFF01, 24'hF77007);
      send_check(16'h01FF, 24'h007F77);
      step();
      @(negedge clock);
      check("count3", 64'(a_count), 64'(3));

      // Clear, then 16 back-to-back words.
      step();
      count_clear = 1'b1;
      step();
      count_clear = 1'b0;
      @(negedge clock);
      check("clear_a", 64'(a_count), 64'(0));
      check("clear_b", 64'(b_count), 64'(0));
      for (int i = 0; i < 16; i++) begin
         step();
         data       = 16'($urandom);
         data_valid = 1'b1;
         @(negedge clock);
         check("b2b_ready", 64'(a_data_ready), 64'(1));
      end
      step();
      data_valid = 1'b0;
      step();
      step();
      @(negedge clock);
      check("b2b_count", 64'(a_count), 64'(16));
      check("b2b_sat_b", 64'(b_count), 64'(15));
      check("b2b_drain", 64'(sbq.size()), 64'(0));

      // Downstream stall with a continuous offered stream.
      step();
      block_ready = 1'b0;
      data        = 16'($urandom);
      data_valid  = 1'b1;
      nacc        = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         acc = data_valid && a_data_ready;
         if (acc) nacc++;
         step();
         if (acc) data = 16'($urandom);
      end
      @(negedge clock);
      check("stall_acc", 64'(nacc), 64'(2));
      check("stall_ready", 64'(a_data_ready), 64'(0));
      check("stall_valid", 64'(a_block_valid), 64'(1));
      step();
      block_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         acc = data_valid && a_data_ready;
         step();
         if (acc) data = 16'($urandom);
      end
      data_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      @(negedge clock);
      check("stall_drain", 64'(sbq.size()), 64'(0));
      check("sat_b", 64'(b_count), 64'(15));

      // Clear wins over a same-cycle handshake.
      step();
      data       = 16'h1234;
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      step();
      count_clear = 1'b1;
      @(negedge clock);
      check("clr_hs_valid", 64'(a_block_valid), 64'(1));
      step();
      count_clear = 1'b0;
      @(negedge clock);
      check("clr_hs_a", 64'(a_count), 64'(0));
      check("clr_hs_b", 64'(b_count), 64'(0));

`ifdef HAMMING_STREAM_PACKAGER_ERROR_INJECTION_EN
      sb_en = 1'b0;
      step();
      block_ready = 1'b0;
      data        = 16'h0001;
      inject_mask = 24'h000004;
      data_valid  = 1'b1;
      step();
      data_valid = 1'b0;
      step();
      inject_mask = 24'hFFFFFF;
      @(negedge clock);
      check("inj_block", 64'(a_block), 64'(24'h000003));
      check("inj_block_b", 64'(b_block), 64'(12'h003));
      step();
      step();
      @(negedge clock);
      check("inj_hold", 64'(a_block), 64'(24'h000003));
      step();
      block_ready = 1'b1;
      inject_mask = '0;
      step();
      step();
      sb_en = 1'b1;
`endif

      // Reset with words in flight.
      for (int i = 0; i < 4; i++) begin
         step();
         data       = 16'($urandom);
         data_valid = 1'b1;
      end
      step();
      resetn = 1'b0;
      @(negedge clock);
      check("pre_rst_valid", 64'(a_block_valid), 64'(1));
      step();
      resetn     = 1'b1;
      data_valid = 1'b0;
      sbq.delete();
      @(negedge clock);
      check("mid_rst_valid", 64'(a_block_valid), 64'(0));
      check("mid_rst_count", 64'(a_count), 64'(0));
      check("mid_rst_count_b", 64'(b_count), 64'(0));
      check("mid_rst_ready", 64'(a_data_ready), 64'(1));

      send_check(16'hFF01, 24'hF77007);
      step();
      step();
      @(negedge clock);
      check("final_drain", 64'(sbq.size()), 64'(0));
      check("final_count", 64'(a_count), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
